// File: rtl/mips_pkg.sv
// Shared memory-stage types and constants: access FSM states, timeout
// defaults and the data word returned when an access is abandoned.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [31:0] MEM_TIMEOUT_DATA     = 32'hDEAD_BEEF;
    localparam int          MEM_TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/acknowledge data-memory bus between the memory-stage controller
// (master) and the data memory (slave).
interface mem_stage_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// 8-bit BUSY-cycle counter; expired is high during the LIMIT-th counted cycle
// (count value LIMIT-1), so the caller can abort at the end of that cycle.
module mem_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: EX/MEM request -> req/ack bus transaction
// with pipeline stall and timeout. Optional macro MEM_ALIGN_CHECK_EN rejects
// misaligned word accesses without touching the bus.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_dm_M,
    input  logic                     dm2reg_M,
    input  logic [31:0]              alu_out_M,
    input  logic [31:0]              wd_dm_M,
    output logic                     stall_M,
    output logic [31:0]              rd_dm_M,
    output logic                     done_M,
    output logic                     bus_err_M,
    output logic                     misalign_M,
    mem_stage_ctrl_if.master         bus
);

    mem_state_t  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic access_M;
    logic misaligned;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;

    assign access_M = we_dm_M | dm2reg_M;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (alu_out_M[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_M) begin
                    if (misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        rd_d    = 32'd0;
                    end else begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        we_d    = we_dm_M;
                        addr_d  = alu_out_M;
                        wdata_d = wd_dm_M;
                        cnt_clr = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack in the final allowed cycle takes priority over the timeout.
                if (bus.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rd_d = bus.mem_rdata;
                    end
                end else if (cnt_expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = MEM_TIMEOUT_DATA;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // DONE releases the stall so EX/MEM advances exactly once per access.
    assign stall_M       = access_M & (state_q != DONE);
    assign rd_dm_M       = rd_q;
    assign done_M        = done_q;
    assign bus_err_M     = err_q;
    assign misalign_M    = mis_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-cycle vector table plus hand-written
// reset-mid-access and (with MEM_ALIGN_CHECK_EN) misaligned-access sequences.
module tb_mem_stage_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_dm_M, dm2reg_M;
    logic [31:0] alu_out_M, wd_dm_M;
    logic        stall_M, done_M, bus_err_M, misalign_M;
    logic [31:0] rd_dm_M;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_ctrl_if bus_if ();

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_dm_M    (we_dm_M),
        .dm2reg_M   (dm2reg_M),
        .alu_out_M  (alu_out_M),
        .wd_dm_M    (wd_dm_M),
        .stall_M    (stall_M),
        .rd_dm_M    (rd_dm_M),
        .done_M     (done_M),
        .bus_err_M  (bus_err_M),
        .misalign_M (misalign_M),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        we, ld;
        logic [31:0] addr, wd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_req, e_done, e_err;
        logic        chk_bus, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic we, input logic ld, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ack, input logic [31:0] rdata,
                       input logic e_stall, input logic e_req, input logic e_done, input logic e_err,
                       input logic chk_bus, input logic e_we, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [31:0] e_rd);
        vec_t v;
        v.tag = tag; v.we = we; v.ld = ld; v.addr = addr; v.wd = wd; v.ack = ack; v.rdata = rdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_done = e_done; v.e_err = e_err;
        v.chk_bus = chk_bus; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.chk_rd = 1'b1; v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    task automatic drive(input logic we, input logic ld, input logic [31:0] addr,
                         input logic [31:0] wd, input logic ack, input logic [31:0] rdata);
        we_dm_M = we; dm2reg_M = ld; alu_out_M = addr; wd_dm_M = wd;
        bus_if.mem_ack = ack; bus_if.mem_rdata = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // tag, we, ld, addr, wd, ack, rdata | stall req done err | bus we addr wdata | rd
        add("ld0", 0, 1, 32'h100, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        add("ld1", 0, 1, 32'h100, 0, 0, 0,              1, 1, 0, 0, 1, 0, 32'h100, 0, 32'h0);
        add("ld2", 0, 1, 32'h100, 0, 0, 0,              1, 1, 0, 0, 1, 0, 32'h100, 0, 32'h0);
        add("ld3", 0, 1, 32'h100, 0, 1, 32'h12345678,   1, 1, 0, 0, 1, 0, 32'h100, 0, 32'h0);
        add("ld4", 0, 1, 32'h100, 0, 0, 0,              0, 0, 1, 0, 0, 0, 0, 0, 32'h12345678);
        add("ld5", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        add("st0", 1, 0, 32'h40, 32'hCAFEF00D, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        add("st1", 1, 0, 32'h40, 32'hCAFEF00D, 1, 32'hFFFFFFFF,
                                                        1, 1, 0, 0, 1, 1, 32'h40, 32'hCAFEF00D, 32'h12345678);
        add("st2", 1, 0, 32'h40, 32'hCAFEF00D, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0, 32'h12345678);
        add("st3", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        add("to0", 0, 1, 32'h200, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        for (int i = 1; i <= 4; i++)
            add($sformatf("to%0d", i), 0, 1, 32'h200, 0, 0, 0,
                                                        1, 1, 0, 0, 1, 0, 32'h200, 0, 32'h12345678);
        add("to5", 0, 1, 32'h200, 0, 0, 0,              0, 0, 1, 1, 0, 0, 0, 0, 32'hDEADBEEF);
        add("to6", 0, 0, 0, 0, 1, 32'h11111111,         0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        add("to7", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        add("lc0", 0, 1, 32'h300, 0, 0, 0,              1, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        for (int i = 1; i <= 3; i++)
            add($sformatf("lc%0d", i), 0, 1, 32'h300, 0, 0, 0,
                                                        1, 1, 0, 0, 1, 0, 32'h300, 0, 32'hDEADBEEF);
        add("lc4", 0, 1, 32'h300, 0, 1, 32'h0BADF00D,   1, 1, 0, 0, 1, 0, 32'h300, 0, 32'hDEADBEEF);
        add("lc5", 0, 1, 32'h300, 0, 0, 0,              0, 0, 1, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("lc6", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("bh0", 1, 1, 32'h80, 32'h55AA55AA, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("bh1", 1, 1, 32'h80, 32'h55AA55AA, 1, 32'h99999999,
                                                        1, 1, 0, 0, 1, 1, 32'h80, 32'h55AA55AA, 32'h0BADF00D);
        add("bh2", 1, 1, 32'h80, 32'h55AA55AA, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("bh3", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("sp0", 0, 0, 0, 0, 1, 32'h33333333,         0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("sp1", 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);
        add("sp2", 0, 0, 0, 0, 1, 32'h44444444,         0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall_M), 0);
        chk("rst_req", 32'(bus_if.mem_req), 0);
        chk("rst_we", 32'(bus_if.mem_we), 0);
        chk("rst_addr", bus_if.mem_addr, 0);
        chk("rst_wdata", bus_if.mem_wdata, 0);
        chk("rst_rd", rd_dm_M, 0);
        chk("rst_done", 32'(done_M), 0);
        chk("rst_err", 32'(bus_err_M), 0);
        chk("rst_mis", 32'(misalign_M), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].we, vq[i].ld, vq[i].addr, vq[i].wd, vq[i].ack, vq[i].rdata);
            @(negedge clk);
            chk({vq[i].tag, "_stall"}, 32'(stall_M), 32'(vq[i].e_stall));
            chk({vq[i].tag, "_req"}, 32'(bus_if.mem_req), 32'(vq[i].e_req));
            chk({vq[i].tag, "_done"}, 32'(done_M), 32'(vq[i].e_done));
            chk({vq[i].tag, "_err"}, 32'(bus_err_M), 32'(vq[i].e_err));
            chk({vq[i].tag, "_mis"}, 32'(misalign_M), 0);
            if (vq[i].chk_bus) begin
                chk({vq[i].tag, "_we"}, 32'(bus_if.mem_we), 32'(vq[i].e_we));
                chk({vq[i].tag, "_addr"}, bus_if.mem_addr, vq[i].e_addr);
                chk({vq[i].tag, "_wdata"}, bus_if.mem_wdata, vq[i].e_wdata);
            end
            if (vq[i].chk_rd) chk({vq[i].tag, "_rd"}, rd_dm_M, vq[i].e_rd);
            $display("vec %s: stall=%0b req=%0b we=%0b addr=%h done=%0b err=%0b rd=%h",
                     vq[i].tag, stall_M, bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr,
                     done_M, bus_err_M, rd_dm_M);
            next_cycle();
        end

        // Reset in cycle 2 of a load; late ack in cycle 3 must be ignored.
        drive(0, 1, 32'h104, 0, 0, 0);       // cycle 0
        next_cycle();                         // cycle 1
        chk("rm_c1_req", 32'(bus_if.mem_req), 1);
        next_cycle();                         // cycle 2
        rst_n = 1'b0;
        next_cycle();                         // cycle 3
        rst_n = 1'b1;
        drive(0, 1, 32'h104, 0, 1, 32'h66666666);
        @(negedge clk);
        chk("rm_c3_req", 32'(bus_if.mem_req), 0);
        chk("rm_c3_we", 32'(bus_if.mem_we), 0);
        chk("rm_c3_addr", bus_if.mem_addr, 0);
        chk("rm_c3_wdata", bus_if.mem_wdata, 0);
        chk("rm_c3_rd", rd_dm_M, 0);
        chk("rm_c3_done", 32'(done_M), 0);
        chk("rm_c3_err", 32'(bus_err_M), 0);
        chk("rm_c3_mis", 32'(misalign_M), 0);
        chk("rm_c3_state", 32'(dut.state_q), 32'(IDLE));
        $display("reset mid-access: req=%0b rd=%h done=%0b", bus_if.mem_req, rd_dm_M, done_M);
        next_cycle();                         // cycle 4
        drive(0, 1, 32'h104, 0, 1, 32'h00000077);
        @(negedge clk);
        chk("rm_c4_req", 32'(bus_if.mem_req), 1);
        chk("rm_c4_addr", bus_if.mem_addr, 32'h104);
        next_cycle();                         // cycle 5
        drive(0, 1, 32'h104, 0, 0, 0);
        @(negedge clk);
        chk("rm_c5_done", 32'(done_M), 1);
        chk("rm_c5_rd", rd_dm_M, 32'h77);
        chk("rm_c5_stall", 32'(stall_M), 0);
        $display("reissue after reset: done=%0b rd=%h", done_M, rd_dm_M);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();

`ifdef MEM_ALIGN_CHECK_EN
        drive(0, 1, 32'h102, 0, 0, 0);       // cycle 0
        @(negedge clk);
        chk("ma_c0_stall", 32'(stall_M), 1);
        chk("ma_c0_req", 32'(bus_if.mem_req), 0);
        next_cycle();                         // cycle 1
        @(negedge clk);
        chk("ma_c1_req", 32'(bus_if.mem_req), 0);
        chk("ma_c1_done", 32'(done_M), 1);
        chk("ma_c1_mis", 32'(misalign_M), 1);
        chk("ma_c1_rd", rd_dm_M, 0);
        chk("ma_c1_stall", 32'(stall_M), 0);
        $display("misaligned: done=%0b mis=%0b rd=%h", done_M, misalign_M, rd_dm_M);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ma_c2_req", 32'(bus_if.mem_req), 0);
        chk("ma_c2_mis", 32'(misalign_M), 0);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and turns them into a request/acknowledge data-memory bus transaction. It stalls the upstream pipeline while an access is outstanding. It returns load data to the MEM/WB path, and it bounds every access with a timeout. It sits between the EX/MEM register and the MEM/WB register, alongside the data memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum number of BUSY cycles to wait for `mem_ack` before aborting. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock; one clock domain only.
- rst_n  in  1  synchronous, active-low reset.
- we_dm_M  in  1  store request from EX/MEM.
- dm2reg_M  in  1  load request from EX/MEM.
- alu_out_M  in  32  byte address of the access.
- wd_dm_M  in  32  store data.
- stall_M  out  1  freezes PC, IF/ID, ID/EXE and EX/MEM. Combinational.
- rd_dm_M  out  32  captured load data, registered.
- done_M  out  1  one-cycle pulse marking access completion (the DONE state).
- bus_err_M  out  1  high during DONE when the access timed out.
- misalign_M  out  1  misaligned word access; see Configuration.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  bus write enable, registered.
- mem_addr  out  32  bus address, registered.
- mem_wdata  out  32  bus write data, registered.
- mem_ack  in  1  bus acknowledge.
- mem_rdata  in  32  bus read data, valid when `mem_ack` is high.

## Operation
- access_M = we_dm_M | dm2reg_M. If both are high, the access is a store (mem_we=1), and a load is not performed.
- FSM states and transitions:
  - IDLE: if access_M, go to BUSY and load mem_req=1, mem_we=we_dm_M, mem_addr=alu_out_M, mem_wdata=wd_dm_M.
  - BUSY: if mem_ack, go to DONE and clear mem_req. If the access is a load, capture mem_rdata into rd_dm_M. Otherwise, when the timeout expires, go to DONE with the error flag set.
  - DONE: unconditionally go to IDLE.
- stall_M = access_M & (state != DONE). No stall occurs when there is no access.
- In DONE, the EX/MEM register advances on the next edge. Because the FSM is back in IDLE when the next instruction arrives, the same instruction is never re-issued.
- Timeout counter:
  - Cleared when BUSY is entered; increments on each BUSY cycle that has no ack.
  - If no ack has arrived by the end of the TIMEOUT_CYCLES-th BUSY cycle, go to DONE with bus_err_M=1 and rd_dm_M=32'hDEAD_BEEF.
  - An ack arriving in that last cycle wins over the timeout.
- Bus handshake rules:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
  - mem_ack is ignored outside BUSY.
- rd_dm_M holds its value across stores, timeouts excepted.
- Reset, including mid-BUSY: state goes to IDLE and mem_req, mem_we, mem_addr, mem_wdata, rd_dm_M, done_M, bus_err_M and misalign_M all go to 0. A late ack from the abandoned transaction is ignored. If access_M is still high after reset, the access re-issues from IDLE.

## Timing
- Cycle 0: the access is present in M and the FSM is in IDLE. stall_M=1.
- Cycle 1: mem_req=1.
- If the ack arrives in cycle k (k≥1), DONE occurs in cycle k+1. In that cycle stall_M=0, done_M=1 and rd_dm_M is valid.
- Minimum occupancy is 3 cycles per memory instruction. Back-to-back accesses therefore issue mem_req every 3 cycles at best.
- Worst case, a timeout, gives a DONE in cycle TIMEOUT_CYCLES+1.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE, an access with alu_out_M[1:0]!=0 issues no bus request and goes directly to DONE.
  - In that DONE cycle misalign_M=1 and rd_dm_M=0; timing is cycle 0 stall, cycle 1 DONE.
- MEM_ALIGN_CHECK_EN undefined:
  - misalign_M is tied to 0.
  - The address is forwarded unmodified.
  - The port is still present.

## Structure
- The shared package mips_pkg holds:
  - mem_state_t enum (IDLE, BUSY, DONE).
  - MEM_TIMEOUT_DATA = 32'hDEAD_BEEF.
  - The default TIMEOUT_CYCLES value.
- Sub-module mem_timeout_cnt: 8-bit counter with clear, enable and an expired output, reset by rst_n.

## Test plan
- Load: dm2reg_M=1, alu_out_M=0x100, ack with rdata 0x12345678 in cycle 3. Required: mem_req high in cycles 1–3, mem_we=0, stall_M high in cycles 0–3, and in cycle 4 done_M=1 with rd_dm_M=0x12345678.
- Store: we_dm_M=1, alu_out_M=0x40, wd_dm_M=0xCAFEF00D, ack in cycle 1. Required: mem_we=1, mem_addr=0x40 and mem_wdata=0xCAFEF00D in cycle 1, done_M in cycle 2, rd_dm_M unchanged.
- Timeout: TIMEOUT_CYCLES=4, no ack. Required: mem_req high in cycles 1–4, and in cycle 5 bus_err_M=1 with rd_dm_M=0xDEADBEEF. A stray ack in cycle 6 has no effect.
- Reset mid-access: rst_n low during cycle 2 of a load. Required: in cycle 3 every output is 0 and the FSM is in IDLE. With access_M held high, mem_req reasserts in cycle 4.
- Idle and spurious ack: access_M=0 with mem_ack pulsed. Required: stall_M=0 and mem_req=0 throughout, with no done_M.
- Misaligned load with MEM_ALIGN_CHECK_EN, alu_out_M=0x102. Required: mem_req is never asserted, and in cycle 1 done_M=1, misalign_M=1 and rd_dm_M=0.
